// File: rtl/cla_seq_adder_ctrl_pkg.sv
// Shared definitions for the multi-cycle carry-lookahead adder controller.
// Holds:
//   - the controller state encoding
//   - the default operand and chunk widths
//   - elaboration-time width helpers
package cla_seq_adder_ctrl_pkg;

  localparam int WIDTH_DEF = 64;
  localparam int CHUNK_DEF = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

  // Index width that never collapses to zero bits (single-chunk builds).
  function automatic int idx_w(input int n);
    return (n > 1) ? clog2(n) : 1;
  endfunction

endpackage

// File: rtl/cla_seq_adder_ctrl_if.sv
// Operand / result bundle for cla_seq_adder_ctrl.
// The requester side (master) drives:
//   - flush
//   - in_valid, a, b, sub, cin
//   - out_ready
// The adder side (slave) drives:
//   - in_ready
//   - out_valid, sum, cout, ovf
//   - busy, chunk_idx
interface cla_seq_adder_ctrl_if
  import cla_seq_adder_ctrl_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int CHUNK = CHUNK_DEF
);
  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IDXW   = idx_w(NCHUNK);

  logic              flush;
  logic              in_valid;
  logic              in_ready;
  logic [WIDTH-1:0]  a;
  logic [WIDTH-1:0]  b;
  logic              sub;
  logic              cin;
  logic              out_valid;
  logic              out_ready;
  logic [WIDTH-1:0]  sum;
  logic              cout;
  logic              ovf;
  logic              busy;
  logic [IDXW-1:0]   chunk_idx;

  modport master (
    output flush, in_valid, a, b, sub, cin, out_ready,
    input  in_ready, out_valid, sum, cout, ovf, busy, chunk_idx
  );

  modport slave (
    input  flush, in_valid, a, b, sub, cin, out_ready,
    output in_ready, out_valid, sum, cout, ovf, busy, chunk_idx
  );
endinterface

// File: rtl/cla_seq_adder_ctrl_cla_chunk.sv
// cla_chunk: purely combinational CHUNK-bit two-level carry-lookahead adder.
// The lookahead works in two levels:
//   - Bit-level p/g are folded into 4-bit group P/G.
//   - A second lookahead level across the CHUNK/4 groups produces each
//     group's carry-in.
//   - Carries inside a group are then expanded from that group carry-in.
// Ports:
//   a, b : CHUNK-bit addends
//   cin  : carry into bit 0
//   sum  : CHUNK-bit sum
//   cout : carry out of bit CHUNK-1
module cla_chunk
  import cla_seq_adder_ctrl_pkg::*;
#(
  parameter int CHUNK = CHUNK_DEF
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             cin,
  output logic [CHUNK-1:0] sum,
  output logic             cout
);
  localparam int NG = CHUNK / 4;

  logic [CHUNK-1:0] w_p;
  logic [CHUNK-1:0] w_g;
  logic [NG-1:0]    w_gp;
  logic [NG-1:0]    w_gg;
  logic [NG:0]      w_cgrp;
  logic [CHUNK-1:0] w_cbit;

  // Sum-of-products lookahead:
  //   carry into position n =
  //       OR over j<n of g[j] & p[j+1..n-1]
  //     | c0 & p[0..n-1]
  // Written flat (not as a ripple recurrence) so each carry is a two-level
  // function of p/g and c0.
  function automatic logic lookahead(input logic [CHUNK-1:0] gv,
                                     input logic [CHUNK-1:0] pv,
                                     input logic c0,
                                     input int n);
    logic c;
    logic t;
    t = c0;
    for (int m = 0; m < CHUNK; m++) if (m < n) t &= pv[m];
    c = t;
    for (int j = 0; j < CHUNK; j++) begin
      t = gv[j];
      for (int m = 0; m < CHUNK; m++) if (m > j && m < n) t &= pv[m];
      if (j < n) c |= t;
    end
    return c;
  endfunction

  assign w_p = a ^ b;
  assign w_g = a & b;

  always_comb begin
    w_gp   = '0;
    w_gg   = '0;
    w_cgrp = '0;
    w_cbit = '0;
    for (int k = 0; k < NG; k++) begin
      w_gp[k] = &w_p[4*k +: 4];
      w_gg[k] = lookahead(CHUNK'(w_g[4*k +: 4]), CHUNK'(w_p[4*k +: 4]), 1'b0, 4);
    end
    for (int k = 0; k <= NG; k++) begin
      w_cgrp[k] = lookahead(CHUNK'(w_gg), CHUNK'(w_gp), cin, k);
    end
    for (int k = 0; k < NG; k++) begin
      for (int i = 0; i < 4; i++) begin
        w_cbit[4*k+i] = lookahead(CHUNK'(w_g[4*k +: 4]), CHUNK'(w_p[4*k +: 4]),
                                  w_cgrp[k], i);
      end
    end
  end

  assign sum  = w_p ^ w_cbit;
  assign cout = w_cgrp[NG];

endmodule

// File: rtl/cla_seq_adder_ctrl.sv
// cla_seq_adder_ctrl: multi-cycle WIDTH-bit add/subtract built around one
// CHUNK-bit lookahead slice.
// Operation:
//   - Operands are captured on the accept edge.
//   - One chunk is processed per cycle, LSB chunk first.
//   - The chunk carry is registered between cycles.
//   - The result is held until the consumer takes it.
// Ports:
//   clk   : clock
//   rst_n : async active-low reset
//   bus   : slave side of cla_seq_adder_ctrl_if
//           (flush, input handshake and operands, output handshake and
//            result, busy, chunk_idx)
//
// state | meaning
// IDLE  | in_ready high, waiting for in_valid
// RUN   | one chunk added per cycle, chunk_idx walks 0..NCHUNK-1
// DONE  | out_valid high, result frozen until out_ready
module cla_seq_adder_ctrl
  import cla_seq_adder_ctrl_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int CHUNK = CHUNK_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  cla_seq_adder_ctrl_if.slave  bus
);
  localparam int              NCHUNK = WIDTH / CHUNK;
  localparam int              IDXW   = idx_w(NCHUNK);
  localparam logic [IDXW-1:0] LAST   = IDXW'(NCHUNK - 1);

  state_t                        r_state;
  logic [WIDTH-1:0]              r_op_a;
  logic [WIDTH-1:0]              r_op_b;   // already inverted for subtract
  logic                          r_carry;
  logic [IDXW-1:0]               r_idx;
  logic [NCHUNK-1:0][CHUNK-1:0]  r_sum_ch;
  logic                          r_cout;
  logic                          r_ovf;
  logic                          r_in_ready;
  logic                          r_out_valid;
  logic                          r_busy;

  logic [NCHUNK-1:0][CHUNK-1:0]  w_a_ch;
  logic [NCHUNK-1:0][CHUNK-1:0]  w_b_ch;
  logic [CHUNK-1:0]              w_sum;
  logic                          w_cout;

  assign w_a_ch = r_op_a;
  assign w_b_ch = r_op_b;

  cla_chunk #(.CHUNK(CHUNK)) u_chunk (
    .a    (w_a_ch[r_idx]),
    .b    (w_b_ch[r_idx]),
    .cin  (r_carry),
    .sum  (w_sum),
    .cout (w_cout)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_op_a      <= '0;
      r_op_b      <= '0;
      r_carry     <= 1'b0;
      r_idx       <= '0;
      r_sum_ch    <= '0;
      r_cout      <= 1'b0;
      r_ovf       <= 1'b0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
    end else if (bus.flush) begin
      // Abort wins over any accept; sum is left as-is but no longer valid.
      r_state     <= ST_IDLE;
      r_carry     <= 1'b0;
      r_idx       <= '0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (bus.in_valid) begin
            r_op_a     <= bus.a;
            r_op_b     <= bus.sub ? ~bus.b : bus.b;
            // Subtract is A + ~B + 1; a borrow-in cancels the +1.
            r_carry    <= bus.cin ^ bus.sub;
            r_idx      <= '0;
            r_state    <= ST_RUN;
            r_in_ready <= 1'b0;
            r_busy     <= 1'b1;
          end
        end
        ST_RUN: begin
          r_sum_ch[r_idx] <= w_sum;
          r_carry         <= w_cout;
          if (r_idx == LAST) begin
            r_cout      <= w_cout;
            r_ovf       <= (r_op_a[WIDTH-1] == r_op_b[WIDTH-1]) &&
                           (w_sum[CHUNK-1] != r_op_a[WIDTH-1]);
            r_idx       <= '0;
            r_state     <= ST_DONE;
            r_out_valid <= 1'b1;
          end else begin
            r_idx <= r_idx + 1'b1;
          end
        end
        ST_DONE: begin
          if (bus.out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_busy      <= 1'b0;
            r_state     <= ST_IDLE;
          end
        end
        default: begin
          r_state     <= ST_IDLE;
          r_in_ready  <= 1'b1;
          r_out_valid <= 1'b0;
          r_busy      <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready  = r_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.sum       = r_sum_ch;
  assign bus.cout      = r_cout;
  assign bus.ovf       = r_ovf;
  assign bus.busy      = r_busy;
  assign bus.chunk_idx = r_idx;

endmodule

// File: tb/tb_cla_seq_adder_ctrl.sv
// Self-checking bench for cla_seq_adder_ctrl (WIDTH=64, CHUNK=16).
// Expected results are pushed to a scoreboard queue when an operation is
// issued and popped when out_valid appears.
module tb_cla_seq_adder_ctrl;
  localparam int WIDTH  = 64;
  localparam int CHUNK  = 16;
  localparam int NCHUNK = WIDTH / CHUNK;

  typedef struct {
    logic [63:0] sum;
    logic        cout;
    logic        ovf;
  } exp_t;

  logic clk;
  logic rst_n;
  int   n_checks = 0;
  int   n_err    = 0;
  exp_t sb[$];
  exp_t e;

  cla_seq_adder_ctrl_if #(.WIDTH(WIDTH), .CHUNK(CHUNK)) u_if ();

  cla_seq_adder_ctrl #(.WIDTH(WIDTH), .CHUNK(CHUNK)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (u_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkw(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic checkb(input string tag, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input logic [63:0] a, input logic [63:0] b,
                                 input logic s, input logic c);
    exp_t        r;
    logic [63:0] bb;
    logic [64:0] full;
    bb     = s ? ~b : b;
    full   = {1'b0, a} + {1'b0, bb} + 65'(c ^ s);
    r.sum  = full[63:0];
    r.cout = full[64];
    r.ovf  = (a[63] == bb[63]) && (full[63] != a[63]);
    return r;
  endfunction

  // Drives one request for a single accept edge, then scrambles the operand
  // inputs to show they are not re-sampled.
  task automatic issue(input logic [63:0] ta, input logic [63:0] tb_b,
                       input logic ts, input logic tc, input exp_t ex);
    sb.push_back(ex);
    u_if.a        = ta;
    u_if.b        = tb_b;
    u_if.sub      = ts;
    u_if.cin      = tc;
    u_if.in_valid = 1'b1;
    tick();
    u_if.in_valid = 1'b0;
    u_if.a        = {$urandom(), $urandom()};
    u_if.b        = {$urandom(), $urandom()};
    u_if.sub      = ~ts;
    u_if.cin      = ~tc;
  endtask

  task automatic collect(input string tag, input bit hs, output exp_t got);
    int n;
    n = 0;
    while (u_if.out_valid !== 1'b1 && n < 40) begin
      if (n < NCHUNK) checkw({tag, "_chunk_idx"}, 64'(u_if.chunk_idx), 64'(n));
      tick();
      n++;
    end
    checkw({tag, "_latency"}, 64'(n), 64'(NCHUNK));
    n_checks++;
    assert (sb.size() > 0) else begin
      n_err++;
      $error("FAIL %s_scoreboard: observed=empty expected=entry", tag);
    end
    got = '{sum: '0, cout: 1'b0, ovf: 1'b0};
    if (sb.size() > 0) begin
      got = sb.pop_front();
      checkw({tag, "_sum"}, u_if.sum, got.sum);
      checkb({tag, "_cout"}, u_if.cout, got.cout);
      checkb({tag, "_ovf"}, u_if.ovf, got.ovf);
    end
    if (hs) begin
      u_if.out_ready = 1'b1;
      tick();
      u_if.out_ready = 1'b0;
      checkb({tag, "_ov_drop"}, u_if.out_valid, 1'b0);
      checkb({tag, "_ir_back"}, u_if.in_ready, 1'b1);
    end
  endtask

  initial begin
    rst_n          = 1'b0;
    u_if.flush     = 1'b0;
    u_if.in_valid  = 1'b0;
    u_if.a         = '0;
    u_if.b         = '0;
    u_if.sub       = 1'b0;
    u_if.cin       = 1'b0;
    u_if.out_ready = 1'b0;
    #12;
    checkb("rst_in_ready", u_if.in_ready, 1'b1);
    checkb("rst_out_valid", u_if.out_valid, 1'b0);
    checkb("rst_busy", u_if.busy, 1'b0);
    checkw("rst_sum", u_if.sum, 64'h0);
    checkb("rst_cout", u_if.cout, 1'b0);
    checkb("rst_ovf", u_if.ovf, 1'b0);
    checkw("rst_idx", 64'(u_if.chunk_idx), 64'h0);
    rst_n = 1'b1;
    tick();

    // Full carry ripple through every chunk
    issue(64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0,
          '{sum: 64'h0, cout: 1'b1, ovf: 1'b0});
    checkb("ripple_busy", u_if.busy, 1'b1);
    checkb("ripple_in_ready", u_if.in_ready, 1'b0);
    collect("ripple", 1'b1, e);
    tick();

    // Signed overflow
    issue(64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0,
          '{sum: 64'h8000_0000_0000_0000, cout: 1'b0, ovf: 1'b1});
    collect("ovf", 1'b1, e);

    // Subtract, no borrow-in, negative result
    issue(64'h5, 64'h7, 1'b1, 1'b0,
          '{sum: 64'hFFFF_FFFF_FFFF_FFFE, cout: 1'b0, ovf: 1'b0});
    collect("sub_neg", 1'b1, e);

    // Subtract with borrow-in
    issue(64'h7, 64'h5, 1'b1, 1'b1, '{sum: 64'h1, cout: 1'b1, ovf: 1'b0});
    collect("sub_bin", 1'b1, e);

    // Random mixed operations against the arithmetic model
    for (int i = 0; i < 4; i++) begin
      logic [63:0] ra, rb;
      logic        rs, rc;
      ra = {$urandom(), $urandom()};
      rb = {$urandom(), $urandom()};
      rs = 1'($urandom_range(0, 1));
      rc = 1'($urandom_range(0, 1));
      issue(ra, rb, rs, rc, model(ra, rb, rs, rc));
      collect("rand", 1'b1, e);
    end

    // Backpressure: result frozen, competing request ignored
    issue(64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210, 1'b0, 1'b1,
          '{sum: 64'h0000_0000_0000_0000, cout: 1'b1, ovf: 1'b0});
    collect("bp", 1'b0, e);
    u_if.a        = 64'h1111_2222_3333_4444;
    u_if.b        = 64'h0000_0000_0000_0005;
    u_if.sub      = 1'b1;
    u_if.cin      = 1'b0;
    u_if.in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checkw("bp_sum_hold", u_if.sum, e.sum);
      checkb("bp_cout_hold", u_if.cout, e.cout);
      checkb("bp_ovf_hold", u_if.ovf, e.ovf);
      checkb("bp_out_valid", u_if.out_valid, 1'b1);
      checkb("bp_in_ready", u_if.in_ready, 1'b0);
    end
    u_if.out_ready = 1'b1;
    tick();
    u_if.out_ready = 1'b0;
    checkb("bp_hs_in_ready", u_if.in_ready, 1'b1);
    checkb("bp_hs_busy", u_if.busy, 1'b0);
    checkb("bp_hs_out_valid", u_if.out_valid, 1'b0);
    sb.push_back('{sum: 64'h1111_2222_3333_443F, cout: 1'b1, ovf: 1'b0});
    tick();
    u_if.in_valid = 1'b0;
    checkb("bp_second_accept", u_if.busy, 1'b1);
    collect("bp2", 1'b1, e);

    // Reset in the middle of RUN; stale carry must not leak
    issue(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0,
          model(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0));
    tick();
    tick();
    checkw("mid_idx2", 64'(u_if.chunk_idx), 64'h2);
    rst_n = 1'b0;
    #1;
    checkw("mid_rst_sum", u_if.sum, 64'h0);
    checkb("mid_rst_in_ready", u_if.in_ready, 1'b1);
    checkb("mid_rst_busy", u_if.busy, 1'b0);
    checkb("mid_rst_out_valid", u_if.out_valid, 1'b0);
    checkw("mid_rst_idx", 64'(u_if.chunk_idx), 64'h0);
    sb.delete();
    #2;
    rst_n = 1'b1;
    tick();
    issue(64'h1, 64'h1, 1'b0, 1'b0, '{sum: 64'h2, cout: 1'b0, ovf: 1'b0});
    collect("post_rst", 1'b1, e);

    // Flush during RUN, then a zero add to expose any leftover carry
    issue(64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0, '{sum: 64'h0, cout: 1'b1, ovf: 1'b0});
    tick();
    u_if.flush = 1'b1;
    tick();
    u_if.flush = 1'b0;
    checkb("flush_run_in_ready", u_if.in_ready, 1'b1);
    checkw("flush_run_idx", 64'(u_if.chunk_idx), 64'h0);
    sb.delete();
    issue(64'h0, 64'h0, 1'b0, 1'b0, '{sum: 64'h0, cout: 1'b0, ovf: 1'b0});
    collect("post_flush", 1'b1, e);

    // Flush in DONE
    issue(64'hDEAD_BEEF_0000_0001, 64'h2, 1'b0, 1'b0,
          '{sum: 64'hDEAD_BEEF_0000_0003, cout: 1'b0, ovf: 1'b0});
    collect("fd", 1'b0, e);
    u_if.flush = 1'b1;
    tick();
    u_if.flush = 1'b0;
    checkb("fd_out_valid", u_if.out_valid, 1'b0);
    checkb("fd_in_ready", u_if.in_ready, 1'b1);
    checkb("fd_busy", u_if.busy, 1'b0);
    checkw("fd_sum_kept", u_if.sum, 64'hDEAD_BEEF_0000_0003);

    // Flush together with in_valid in IDLE: no accept
    u_if.flush    = 1'b1;
    u_if.in_valid = 1'b1;
    tick();
    u_if.flush    = 1'b0;
    u_if.in_valid = 1'b0;
    checkb("fi_no_accept_busy", u_if.busy, 1'b0);
    checkb("fi_in_ready", u_if.in_ready, 1'b1);
    tick();
    checkb("fi_still_idle", u_if.busy, 1'b0);

    issue(64'h3, 64'h4, 1'b0, 1'b0, '{sum: 64'h7, cout: 1'b0, ovf: 1'b0});
    collect("final", 1'b1, e);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
